// File: rtl/video_daisy_ctrl_writer.sv
// video_daisy_ctrl_writer: debounced key (plus switch snapshot) triggers one
// Avalon-MM write to each daisy core's control register in index order, with
// a per-write waitrequest timeout that abandons a stuck core.
// Optional feature macro: VIDEO_DAISY_AUTO_UPDATE_EN -- a debounced change of
// the switch vector also starts a sequence.
module video_daisy_ctrl_writer #(
  parameter int NUM_CORES    = 4,
  parameter int ADDR_W       = 1,
  parameter int DATA_W       = 32,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 key_n,
  input  logic [NUM_CORES-1:0] sw,
  output logic [ADDR_W-1:0]    avs_address,
  output logic [DATA_W-1:0]    avs_writedata,
  output logic [NUM_CORES-1:0] avs_write,
  input  logic [NUM_CORES-1:0] avs_waitrequest,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CORES-1:0] err_timeout
);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int WT_W  = $clog2(WAIT_TIMEOUT + 1);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

  state_t               state, state_d;
  logic                 key_s1, key_s2, key_stable;
  logic [DB_W-1:0]      key_cnt;
  logic [NUM_CORES-1:0] sw_s1, sw_s2;
  logic                 key_fire, press;
  logic [NUM_CORES-1:0] snap, cur;
  logic                 pending;
  logic [IDX_W-1:0]     idx;
  logic [WT_W-1:0]      wcnt;
  logic                 last, xfer_end, abandon;

  // two-flop synchronisers; key idles released (1), switches idle 0
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // key debounce: level must differ from stable for DEBOUNCE_CYC cycles
  assign key_fire = (key_s2 != key_stable) && (key_cnt == DB_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_stable <= 1'b1;
      key_cnt    <= '0;
    end else if (key_s2 == key_stable) begin
      key_cnt <= '0;
    end else if (key_fire) begin
      key_stable <= key_s2;
      key_cnt    <= '0;
    end else begin
      key_cnt <= key_cnt + 1'b1;
    end
  end

`ifdef VIDEO_DAISY_AUTO_UPDATE_EN
  logic [NUM_CORES-1:0] sw_stable;
  logic [DB_W-1:0]      sw_cnt;
  logic                 sw_fire;

  assign sw_fire = (sw_s2 != sw_stable) && (sw_cnt == DB_W'(DEBOUNCE_CYC - 1));

  // whole-vector switch debounce; an accepted change counts as a press
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sw_stable <= '0;
      sw_cnt    <= '0;
    end else if (sw_s2 == sw_stable) begin
      sw_cnt <= '0;
    end else if (sw_fire) begin
      sw_stable <= sw_s2;
      sw_cnt    <= '0;
    end else begin
      sw_cnt <= sw_cnt + 1'b1;
    end
  end

  assign press = (key_fire && key_stable) || sw_fire;
`else
  assign press = key_fire && key_stable;
`endif

  assign last          = (idx == IDX_W'(NUM_CORES - 1));
  assign avs_address   = '0;
  assign avs_writedata = DATA_W'(cur[idx]);

  // next state and bus strobes; a write ends on !waitrequest or on timeout
  always_comb begin
    state_d   = state;
    avs_write = '0;
    busy      = 1'b0;
    done      = 1'b0;
    xfer_end  = 1'b0;
    abandon   = 1'b0;
    case (state)
      IDLE: if (press || pending) state_d = WRITE;
      WRITE: begin
        avs_write = NUM_CORES'(1) << idx;
        busy      = 1'b1;
        if (!avs_waitrequest[idx]) begin
          xfer_end = 1'b1;
        end else if (wcnt == WT_W'(WAIT_TIMEOUT - 1)) begin
          xfer_end = 1'b1;
          abandon  = 1'b1;
        end
        if (xfer_end) state_d = last ? DONE : GAP;
      end
      GAP: begin
        busy    = 1'b1;
        state_d = WRITE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = pending ? WRITE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // sequence state: snapshot, pending press, core index, stall count, errors
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      snap        <= '0;
      cur         <= '0;
      pending     <= 1'b0;
      idx         <= '0;
      wcnt        <= '0;
      err_timeout <= '0;
    end else begin
      state <= state_d;
      if (press) snap <= sw_s2;
      // one-deep pending; a press arriving mid-sequence only refreshes snap
      if (press && state != IDLE)
        pending <= 1'b1;
      else if ((state == IDLE || state == DONE) && state_d == WRITE)
        pending <= 1'b0;
      // cur holds the data for the running sequence so a late press
      // cannot change writedata under a stalled write
      if (state == IDLE && state_d == WRITE)
        cur <= press ? sw_s2 : snap;
      else if (state == DONE && state_d == WRITE)
        cur <= snap;
      if (state == IDLE && press)
        err_timeout <= '0;
      else if (abandon)
        err_timeout[idx] <= 1'b1;
      wcnt <= (state == WRITE && !xfer_end) ? wcnt + 1'b1 : '0;
      if (state == WRITE && xfer_end)
        idx <= last ? '0 : idx + 1'b1;
      else if (state == DONE)
        idx <= '0;
    end
  end
endmodule

// File: tb/tb_video_daisy_ctrl_writer.sv
// Scoreboard bench for video_daisy_ctrl_writer: stimulus pushes expected
// completed writes; a negedge monitor pops and compares on each completion.
module tb_video_daisy_ctrl_writer;
  localparam int N  = 4;
  localparam int DB = 8;
  // timeout long enough that one sequence outlasts two key press/release cycles
  localparam int TO = 12;

  typedef struct {
    logic [N-1:0] we;
    logic [31:0]  data;
  } exp_t;

  logic         clk = 0, rst = 1, key_n = 1;
  logic [N-1:0] sw = '0;
  logic [0:0]   avs_address;
  logic [31:0]  avs_writedata;
  logic [N-1:0] avs_write, avs_waitrequest, err_timeout;
  logic         busy, done;

  // slave model: stuck cores, and per-core stalls of stall_len cycles
  logic [N-1:0] stuck = '0, stall_mask = '0;
  int           stall_len = 0;
  int           tb_cyc = 0;
  int           cyc = 0;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   done_cnt = 0, w2_cyc = 0;
  logic [N-1:0] prev_we = '0;
  logic [31:0]  prev_d = '0;
  logic         prev_stall = 0;

  video_daisy_ctrl_writer #(
    .NUM_CORES(N), .ADDR_W(1), .DATA_W(32), .DEBOUNCE_CYC(DB), .WAIT_TIMEOUT(TO)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .key_n(key_n), .sw(sw),
    .avs_address(avs_address), .avs_writedata(avs_writedata), .avs_write(avs_write),
    .avs_waitrequest(avs_waitrequest), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  assign avs_waitrequest = stuck | (avs_write & stall_mask & {N{tb_cyc < stall_len}});

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    tb_cyc <= (avs_write != '0) ? tb_cyc + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops on each completed transfer, checks hold/gap/done rules
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        done_cnt++;
        check("busy_low_on_done", {31'b0, busy}, 0);
      end
      if (avs_write != '0) begin
        check("address", {31'b0, avs_address}, 0);
        if (avs_write == 4'b0100) w2_cyc++;
        if (prev_stall) begin
          check("hold_write", {28'b0, avs_write}, {28'b0, prev_we});
          check("hold_data", avs_writedata, prev_d);
        end else if (prev_we != '0) begin
          check("gap_between_cores", {28'b0, avs_write}, 0);
        end
        if ((avs_waitrequest & avs_write) == '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {28'b0, avs_write}, 0);
          end else begin
            e = exp_q.pop_front();
            check("write_strobe", {28'b0, avs_write}, {28'b0, e.we});
            check("write_data", avs_writedata, e.data);
          end
        end
      end
      prev_we    = avs_write;
      prev_d     = avs_writedata;
      prev_stall = (avs_write != '0) && ((avs_waitrequest & avs_write) != '0);
    end else begin
      prev_we    = '0;
      prev_stall = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input logic [N-1:0] d, input logic [N-1:0] mask);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        e.we   = N'(1) << i;
        e.data = {31'b0, d[i]};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic press(input int lo, input int hi);
    key_n = 0;
    tick(lo);
    key_n = 1;
    tick(hi);
  endtask

  task automatic wait_done(input int target, input int lim);
    int k = 0;
    while (done_cnt < target && k < lim) begin
      tick(1);
      k++;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_write"}, {28'b0, avs_write}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_done"}, {31'b0, done}, 0);
    check({tag, "_err"}, {28'b0, err_timeout}, 0);
  endtask

  initial begin
    int base, t0, k;
    // 1: reset and idle
    tick(3);
    check_idle_outputs("reset");
    check("reset_data", avs_writedata, 0);
    rst = 0;
    tick(50);
    check_idle_outputs("idle50");

    // 2: zero-wait sequence, 2N-1 write cycles then DONE
    sw = 4'b1010;
    push_seq(4'b1010, 4'b1111);
    base = done_cnt;
    key_n = 0;
    k = 0;
    while (avs_write == '0 && k < 40) begin tick(1); k++; end
    check("seq_started", {31'b0, avs_write != '0}, 1);
    t0 = cyc;
    k = 0;
    while (!done && k < 40) begin tick(1); k++; end
    check("first_write_to_done", cyc - t0, 7);
    tick(10);
    key_n = 1;
    tick(20);
    check("done_once", done_cnt, base + 1);
    check("queue_drained_2", exp_q.size(), 0);

    // 3: short glitch ignored
    base = done_cnt;
    press(5, 30);
    check("glitch_no_done", done_cnt, base);
    check("glitch_key_stable", {31'b0, dut.key_stable}, 1);

    // 4a: core 2 stalls 3 cycles, completes on the 4th
    sw = 4'b1111;
    stall_mask = 4'b0100;
    stall_len = 3;
    w2_cyc = 0;
    push_seq(4'b1111, 4'b1111);
    base = done_cnt;
    press(12, 12);
    wait_done(base + 1, 100);
    check("core2_hold_cycles", w2_cyc, 4);
    check("no_timeout_err", {28'b0, err_timeout}, 0);
    stall_mask = '0;

    // 4b: core 2 stuck -> abandoned after TO stalls, others still written
    sw = 4'b1001;
    stuck = 4'b0100;
    w2_cyc = 0;
    push_seq(4'b1001, 4'b1011);
    base = done_cnt;
    press(12, 12);
    wait_done(base + 1, 100);
    check("core2_abandon_cycles", w2_cyc, TO);
    check("timeout_err", {28'b0, err_timeout}, 32'h4);
    check("queue_drained_4", exp_q.size(), 0);
    stuck = '0;

    // 5: presses during busy; one pending sequence, latest snapshot
    stall_mask = 4'b1111;
    stall_len = TO - 1;
    sw = 4'b1100;
    push_seq(4'b1100, 4'b1111);
    base = done_cnt;
    press(12, 12);
    check("err_cleared_on_press", {28'b0, err_timeout}, 0);
    sw = 4'b0110;
    push_seq(4'b0110, 4'b1111);
    press(12, 12);
    press(12, 12);
    wait_done(base + 2, 400);
    tick(150);
    check("no_third_sequence", done_cnt, base + 2);
    check("queue_drained_5", exp_q.size(), 0);
    stall_mask = '0;
    stall_len = 0;

    // 6: reset mid-write (core 2 stalled), then a clean restart at core 0
    stuck = 4'b0100;
    sw = 4'b1111;
    push_seq(4'b1111, 4'b0011);
    key_n = 0;
    k = 0;
    while (avs_write != 4'b0100 && k < 60) begin tick(1); k++; end
    check("reached_core2", {28'b0, avs_write}, 32'h4);
    rst = 1;
    key_n = 1;
    tick(1);
    check_idle_outputs("midreset");
    rst = 0;
    stuck = '0;
    tick(20);
    check("queue_drained_6", exp_q.size(), 0);
    sw = 4'b0011;
    push_seq(4'b0011, 4'b1111);
    base = done_cnt;
    press(12, 12);
    wait_done(base + 1, 100);
    check("queue_drained_6b", exp_q.size(), 0);

`ifdef VIDEO_DAISY_AUTO_UPDATE_EN
    // 7: switch change alone starts a sequence
    sw = 4'b0000;
    tick(40);
    base = done_cnt;
    push_seq(4'b0001, 4'b1111);
    sw = 4'b0001;
    wait_done(base + 1, 100);
    tick(20);
    check("auto_one_sequence", done_cnt, base + 1);
    check("queue_drained_7", exp_q.size(), 0);
`endif

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
